// File: rtl/cnt_sched.sv
// Round-robin scheduler that shares one LEN-bit up-counter between NREQ requesters.
// One requester is granted at a time. Its done pulses when the count reaches its latched target.
module cnt_sched #(
  parameter int LEN  = 3,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LEN-1:0]  tgt,
  input  logic                 tick,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [LEN-1:0]       q,
  output logic [1:0]           dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [LEN-1:0]  q_q, q_d;
  logic [LEN-1:0]  tgt_l_q, tgt_l_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   w_q, w_d;

  logic            found;
  logic [PW-1:0]   win;

  // Search starts just above the last served requester, so it becomes lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tgt_l_d = tgt_l_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    w_d     = w_q;
    case (state_q)
      S_IDLE: begin
        q_d   = '0;
        gnt_d = '0;
        if (found) begin
          tgt_l_d = tgt[int'(win)*LEN +: LEN];
          gnt_d   = ONE_HOT0 << win;
          w_d     = win;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[w_q]) begin
          state_d = S_IDLE;
          q_d     = '0;
          gnt_d   = '0;
          ptr_d   = w_q;
        end else if (q_q == tgt_l_q) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else if (tick) begin
          q_d = q_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        q_d     = '0;
        gnt_d   = '0;
        ptr_d   = w_q;
      end
      default: begin
        state_d = S_IDLE;
        q_d     = '0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      tgt_l_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= PW'(NREQ-1);
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tgt_l_q <= tgt_l_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign q         = q_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched. The driver pushes the expected {done, q} for each interval.
// The negedge monitor pops and compares whenever done pulses.
module tb_cnt_sched;
  localparam int LEN  = 3;
  localparam int NREQ = 4;
  localparam int W    = NREQ + LEN;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*LEN-1:0] tgt;
  logic                tick;
  logic [NREQ-1:0]     gnt, done;
  logic                busy;
  logic [LEN-1:0]      q;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  cnt_sched #(.LEN(LEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .tgt(tgt), .tick(tick),
    .gnt(gnt), .done(done), .busy(busy), .q(q), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tgt(input int i, input int v);
    tgt[i*LEN +: LEN] = LEN'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"}, 32'(gnt), 0);
    check({name, "_q"}, 32'(q), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
  endtask

  // Monitor: pops one expected interval per done pulse, and checks grant shape every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("done_vec", 32'(done), 32'(e[W-1:LEN]));
          check("done_q", 32'(q), 32'(e[LEN-1:0]));
          check("done_in_gnt", 32'(done), 32'(gnt));
        end
      end
    end
  end

  initial begin
    int qm;
    bit ok;
    rst = 1'b1;
    req = '0;
    tgt = '0;
    tick = 1'b0;

    // 1: reset and idle hold
    #10 rst = 1'b0;
    #1;
    check_idle("rst");
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("idle_hold");
    end

    // 2: tgt=5, tick=1
    set_tgt(0, 5);
    tick = 1'b1;
    req = 4'b0001;
    exp_q.push_back({4'b0001, 3'd5});
    step();
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_busy", 32'(busy), 1);
    check("t2_q0", 32'(q), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("t2_q", 32'(q), 32'(k));
      check("t2_nodone", 32'(done), 0);
    end
    step();
    check("t2_done", 32'(done), 32'h1);
    check("t2_gnt_held", 32'(gnt), 32'h1);
    req = '0;
    step();
    check_idle("t2_after");

    // 3: tgt=7, tick toggling; count only on tick edges, no wrap
    set_tgt(0, 7);
    tick = 1'b0;
    req = 4'b0001;
    exp_q.push_back({4'b0001, 3'd7});
    step();
    check("t3_gnt", 32'(gnt), 32'h1);
    qm = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick = i[0];
      step();
      if (qm == 7) begin
        check("t3_done", 32'(done), 32'h1);
        check("t3_q_final", 32'(q), 7);
        ok = 1'b1;
        break;
      end
      if (tick) qm++;
      check("t3_q", 32'(q), 32'(qm));
    end
    if (!ok) check("t3_timeout", 0, 1);
    req = '0;
    tick = 1'b1;
    step();
    check_idle("t3_after");

    // 4: all requesting, tgt=1 each; round-robin order from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_tgt(i, 1);
    tick = 1'b1;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
        step();
        if (gnt != '0) ok = 1'b1;
      end
      if (!ok) check("t4_grant_timeout", 0, 1);
      check("t4_order", 32'(gnt), 32'(1 << (g % NREQ)));
      exp_q.push_back({gnt, 3'd1});
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
        step();
        if (gnt == '0) ok = 1'b1;
      end
      if (!ok) check("t4_release_timeout", 0, 1);
      if (g == 4) req = '0;
    end
    step();
    check_idle("t4_after");

    // 5: tgt=0, tick ignored
    set_tgt(2, 0);
    tick = 1'b0;
    req = 4'b0100;
    exp_q.push_back({4'b0100, 3'd0});
    step();
    check("t5_gnt1", 32'(gnt), 32'h4);
    check("t5_q1", 32'(q), 0);
    check("t5_nodone", 32'(done), 0);
    step();
    check("t5_gnt2", 32'(gnt), 32'h4);
    check("t5_done", 32'(done), 32'h4);
    check("t5_q2", 32'(q), 0);
    req = '0;
    step();
    check_idle("t5_after");

    // 6a: abort at q=3, no done
    set_tgt(1, 6);
    tick = 1'b1;
    req = 4'b0010;
    step();
    check("t6_gnt", 32'(gnt), 32'h2);
    for (int k = 0; k < 3; k++) step();
    check("t6_q3", 32'(q), 3);
    req = '0;
    step();
    check_idle("t6_abort");

    // 6b: async reset at q=3, observed before the next clock edge
    req = 4'b0010;
    step();
    check("t6b_gnt", 32'(gnt), 32'h2);
    for (int k = 0; k < 3; k++) step();
    check("t6b_q3", 32'(q), 3);
    #2 rst = 1'b1;
    req = '0;
    #1;
    check_idle("t6b_async_rst");
    step();
    rst = 1'b0;
    step();
    check_idle("t6b_after");

    step();
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
